instr_encoder: RTL and testbench
================================

# instr_encoder

Assembles RV32 instruction words from separate field values (opcode, rd, rs1, rs2, rs3, funct3, funct7, immediate, format) and emits each word, tagged with a sequential instruction-memory byte address, through a 2-entry output buffer. It is the encoding counterpart of the core's field decoder. Test benches and the boot-ROM generator drive it to build instruction streams, and it writes into instruction memory.

## Interface
Parameters:
- ADDR_W, 10, width of the instruction-memory byte address.
- BASE_ADDR, 0, address assigned to the first word after reset or clear.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; empties buffer, address counter to BASE_ADDR, err to 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  buffer can accept a bundle.
- fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5, R4=6, 7 reserved.
- opcode  in  7 / rd, rs1, rs2, rs3  in  5 each / funct3  in  3 / funct7  in  7 / imm  in  32 (sign-extended immediate).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  byte address of the word.
- err  out  1  sticky error flag.

## Operation
- Accept occurs when in_valid && in_ready. The bundle is encoded combinationally and pushed with the current address. The counter then advances by 4, modulo 2^ADDR_W, so wrap-around is silent.
- Encoding, from MSB to LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - R4: rs3|funct7[1:0]|rs2|rs1|funct3|rd|opcode (only when the macro is enabled, see Configuration).
- Unused immediate bits are ignored, with no range check.
- B or J with imm[0]=1: the word is encoded with the bit dropped, pushed normally, and err is set.
- fmt=7 (or fmt=6 without the macro): the handshake completes, but nothing is pushed, the address does not advance, and err is set.
- Buffer: 2-entry FIFO holding {instr, addr}.
  - in_ready = !full.
  - out_valid = !empty.
  - The head is presented on out_instr/out_addr.
  - Pop occurs when out_valid && out_ready.
- err stays set until clear or reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, counter=BASE_ADDR, buffer empty.
- Latency: a bundle accepted in cycle N appears on out_* in cycle N+1 if the buffer was empty. Throughput is 1 word per cycle while out_ready=1.
- Both in_ready and out_valid are derived from registered occupancy only. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Push and pop in the same cycle with 1 entry: occupancy stays 1, and the new word becomes head next cycle.
- Full (2 entries): in_ready=0. A pop in cycle N raises in_ready in cycle N+1.
- clear has priority over a simultaneous push or pop, and the bundle presented in that cycle is dropped.
- Reset mid-stream discards buffered words immediately (asynchronous).
- The head entry is held stable while out_valid && !out_ready.

## Configuration
- INSTR_ENCODER_R4_EN defined: fmt=6 encodes R4 (fused multiply-add layout) as above.
- Undefined: fmt=6 is treated as reserved (nothing pushed, err set), and rs3 is ignored.

## Structure
- Package instr_encoder_pkg holds:
  - the fmt enum (FMT_R … FMT_R4);
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, MADD);
  - the 32-bit instruction typedef.
- Sub-module enc_fifo: a 2-entry valid/ready FIFO, parameterised on data width (32+ADDR_W).
- Encoding is a combinational function in the package.

## Test plan
- Reset, then fmt=R, opcode=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> next cycle out_instr=0x002081B3, out_addr=0x000.
- Burst of I (addi x1,x0,5), S (sw x2,8(x1)), B (beq x0,x0,imm=-4), J (jal x1,8), U (lui x5,0x12345) with out_ready=1 -> 0x00500093, 0x0020A423, 0xFE000EE3, 0x008000EF, 0x123452B7 at addresses 0x000, 0x004, 0x008, 0x00C, 0x010.
- out_ready=0, push 3 bundles -> in_ready drops after 2 accepts. Raise out_ready -> in_ready returns the cycle after the first pop, order is preserved, and no word is lost.
- fmt=7 -> no out_valid, address not advanced, err=1. Then clear -> err=0 and the next word goes to BASE_ADDR.
- B with imm=5 -> word is emitted with bit 0 dropped, err=1.
- ADDR_W=4: push 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0 (wrap). With INSTR_ENCODER_R4_EN defined, fmt=6 with rs3=4, f7[1:0]=0, rs2=2, rs1=1, rd=3, f3=0, opcode=0x43 -> 0x202081C3.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types, opcode constants and the field-to-word encoder for instr_encoder.
// INSTR_ENCODER_R4_EN enables the fused multiply-add (R4) layout for fmt=6.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_R4  = 3'd6,
    FMT_RSV = 3'd7
  } fmt_e;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] MADD   = 7'h43;

  typedef logic [31:0] instr_t;

  typedef struct packed {
    instr_t word;
    logic   push;
    logic   err;
  } enc_result_t;

  // push=0 marks a reserved format; err also flags an odd B/J offset, whose bit 0 is simply dropped.
  function automatic enc_result_t encode_fields(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rs3,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    enc_result_t r;
`ifndef INSTR_ENCODER_R4_EN
    logic unused_rs3;
    unused_rs3 = ^rs3;
`endif
    r.word = '0;
    r.push = 1'b1;
    r.err  = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: r.word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: r.word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: r.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        r.word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        r.err  = imm[0];
      end
      FMT_U: r.word = {imm[31:12], rd, opcode};
      FMT_J: begin
        r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        r.err  = imm[0];
      end
`ifdef INSTR_ENCODER_R4_EN
      FMT_R4: r.word = {rs3, funct7[1:0], rs2, rs1, funct3, rd, opcode};
`endif
      default: begin
        r.push = 1'b0;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_enc_fifo.sv
// Two-entry valid/ready FIFO; ready and valid come only from registered occupancy.
module enc_fifo #(
  parameter int                 DATA_W   = 42,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Clear outranks any push/pop in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= RST_DATA;
      mem[1] <= RST_DATA;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Builds RV32 instruction words from field values and queues them with sequential byte addresses.
// Define INSTR_ENCODER_R4_EN to encode fmt=6 as R4; otherwise fmt=6 is reserved.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rs3,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam int                DW   = 32 + ADDR_W;

  enc_result_t       enc;
  logic              accept;
  logic              do_push;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DW-1:0]     head;

  always_comb begin
    enc = encode_fields(fmt, opcode, rd, rs1, rs2, rs3, funct3, funct7, imm);
  end

  assign accept  = in_valid && in_ready;
  assign do_push = accept && enc.push;

  // Address wraps silently at 2^ADDR_W; reserved formats leave it untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_cnt <= BASE;
    end else if (clear) begin
      addr_cnt <= BASE;
    end else if (do_push) begin
      addr_cnt <= addr_cnt + ADDR_W'(4);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (accept && enc.err) begin
      err <= 1'b1;
    end
  end

  enc_fifo #(
    .DATA_W   (DW),
    .RST_DATA ({32'h0, BASE})
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid && enc.push),
    .in_ready  (in_ready),
    .in_data   ({enc.word, addr_cnt}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_instr = head[DW-1:ADDR_W];
  assign out_addr  = head[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected words, a monitor checks each pop.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W = 10;
`ifdef INSTR_ENCODER_R4_EN
  localparam bit R4_EN = 1'b1;
`else
  localparam bit R4_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic              clock, reset, clear;
  logic              in_valid, in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2, rs3;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid, out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  int                checks = 0;
  int                errors = 0;
  exp_t              sb[$];
  logic [ADDR_W-1:0] expAddr;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs3       (rs3),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op,
                               input logic [4:0] rdv, rs1v, rs2v, rs3v,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] immv,
                               input bit expPush, input logic [31:0] expInstr);
    bit accepted = 1'b0;
    fmt = f; opcode = op; rd = rdv; rs1 = rs1v; rs2 = rs2v; rs3 = rs3v;
    funct3 = f3; funct7 = f7; imm = immv;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake: got in_ready=0 for 20 cycles, expected acceptance");
    end else begin
      @(posedge clock);
      if (expPush) begin
        sb.push_back({expInstr, expAddr});
        expAddr = expAddr + ADDR_W'(4);
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    sb.delete();
    expAddr = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    checkOutput("drain pending", 32'(sb.size()), 32'd0);
    checkOutput("drain out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected word: got 0x%08h @0x%03h, expected none", out_instr, out_addr);
      end else begin
        e = sb.pop_front();
        checkOutput("out_instr", out_instr, e.instr);
        checkOutput("out_addr", 32'(out_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; rs3 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    expAddr = '0;

    #12;
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset out_instr", out_instr, 32'h0);
    checkOutput("reset out_addr", 32'(out_addr), 32'h0);
    checkOutput("reset err", {31'b0, err}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] single R word");
    applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    @(negedge clock);
    checkOutput("latency out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clock);
    #1;
    drain();

    $display("[TB] I/S/B/J/U burst");
    doClear();
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        1'b1, 32'h00500093);
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8,        1'b1, 32'h0020A423);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        1'b1, 32'h008000EF);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    drain();
    checkOutput("burst err", {31'b0, err}, 32'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    @(negedge clock);
    checkOutput("full in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("held head", out_instr, 32'h002081B3);
    @(posedge clock);
    #1;
    fork
      applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
      begin
        @(negedge clock);
        checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("stall head", out_instr, 32'h002081B3);
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        checkOutput("in_ready before pop", {31'b0, in_ready}, 32'd0);
        @(negedge clock);
        checkOutput("in_ready after pop", {31'b0, in_ready}, 32'd1);
      end
    join
    drain();

    $display("[TB] reserved format and clear");
    applyStimulus(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("reserved out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reserved err", {31'b0, err}, 32'd1);
    @(posedge clock);
    #1;
    applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    drain();
    checkOutput("err sticky", {31'b0, err}, 32'd1);
    doClear();
    @(negedge clock);
    checkOutput("clear err", {31'b0, err}, 32'd0);
    @(posedge clock);
    #1;
    applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    drain();

    $display("[TB] misaligned branch");
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00000263);
    @(negedge clock);
    checkOutput("misaligned err", {31'b0, err}, 32'd1);
    @(posedge clock);
    #1;
    drain();

    $display("[TB] fmt 6");
    doClear();
    applyStimulus(3'd6, 7'h43, 5'd3, 5'd1, 5'd2, 5'd4, 3'd0, 7'd0, 32'd0, R4_EN, 32'h202081C3);
    drain();
    checkOutput("fmt6 err", {31'b0, err}, R4_EN ? 32'd0 : 32'd1);

    $display("[TB] asynchronous reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("async reset out_addr", 32'(out_addr), 32'h0);
    sb.delete();
    expAddr = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    $display("[TB] address wrap");
    for (int i = 0; i < 257; i++) begin
      applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    end
    drain();
    checkOutput("wrap next addr", 32'(expAddr), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
